// File: rtl/serial_add_scheduler.sv
// Round-robin arbiter and sequencer for a shared bit-serial adder.
// Two requesters take turns; each add shifts LSB-first through one full-adder cell.
module serial_add_scheduler #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             busy,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             done,
  output logic             done_id
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             owner;
  logic             last_gnt;
  logic             win;
  logic             s_bit;
  logic             c_next;

  // On a tie the requester that was not granted last wins
  always_comb begin
    win = req1;
    if (req0 && req1) win = ~last_gnt;
  end

  always_comb begin
    s_bit  = a_sh[0] ^ b_sh[0] ^ carry;
    c_next = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      sum      <= '0;
      cout     <= 1'b0;
      done_id  <= 1'b0;
      a_sh     <= '0;
      b_sh     <= '0;
      sum_sh   <= '0;
      cnt      <= '0;
      carry    <= 1'b0;
      owner    <= 1'b0;
      last_gnt <= 1'b1;
    end else begin
      gnt0 <= 1'b0;
      gnt1 <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            gnt0     <= ~win;
            gnt1     <= win;
            busy     <= 1'b1;
            last_gnt <= win;
            owner    <= win;
            a_sh     <= win ? a1 : a0;
            b_sh     <= win ? b1 : b0;
            carry    <= 1'b0;
            sum_sh   <= '0;
            cnt      <= '0;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          carry  <= c_next;
          sum_sh <= {s_bit, sum_sh[WIDTH-1:1]};
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          cnt    <= cnt + 1'b1;
          // The final bit is folded straight into the result so it is valid in DONE
          if (cnt == LAST_BIT) begin
            state   <= DONE;
            done    <= 1'b1;
            sum     <= {s_bit, sum_sh[WIDTH-1:1]};
            cout    <= c_next;
            done_id <= owner;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_scheduler.sv
// Bench for serial_add_scheduler: a cycle-timed transaction model predicts every output;
// directed cases pin literal results, then randomized traffic from both requesters.
module tb_serial_add_scheduler;

  localparam int W = 8;

  logic         clock = 1'b0;
  logic         reset;
  logic         req0, req1;
  logic [W-1:0] a0, b0, a1, b1;
  logic         gnt0, gnt1, busy, cout, done, done_id;
  logic [W-1:0] sum;

  int total = 0;
  int bad   = 0;

  serial_add_scheduler #(.WIDTH(W)) dut (
    .clock(clock), .reset(reset),
    .req0(req0), .a0(a0), .b0(b0),
    .req1(req1), .a1(a1), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1), .busy(busy),
    .sum(sum), .cout(cout), .done(done), .done_id(done_id)
  );

  always #5 clock = ~clock;

  // Transaction model: an accepted add occupies cycles start..start+W, result in the last
  int         cyc = 0;
  bit         m_active = 0;
  int         m_done_cyc = 0;
  bit         m_owner = 0;
  bit         m_last = 1;
  logic [W:0] m_res = '0;
  int         n_done = 0;
  bit         exp_gnt0, exp_gnt1, exp_busy, exp_done, exp_cout, exp_id;
  logic [W-1:0] exp_sum;
  bit         persist = 0;
  bit         rnd = 0;

  task automatic modelStep();
    bit idle, w;
    if (reset) begin
      m_active = 0; m_last = 1;
      exp_gnt0 = 0; exp_gnt1 = 0; exp_busy = 0; exp_done = 0;
      exp_sum = '0; exp_cout = 0; exp_id = 0;
    end else begin
      idle = !m_active || (cyc > m_done_cyc);
      exp_gnt0 = 0; exp_gnt1 = 0;
      if (idle && (req0 || req1)) begin
        w = (req0 && req1) ? !m_last : req1;
        m_last = w; m_owner = w; m_active = 1;
        m_res = w ? ({1'b0, a1} + {1'b0, b1}) : ({1'b0, a0} + {1'b0, b0});
        m_done_cyc = cyc + W + 1;
        if (w) exp_gnt1 = 1; else exp_gnt0 = 1;
      end
      exp_busy = m_active && (cyc + 1 <= m_done_cyc);
      exp_done = m_active && (cyc + 1 == m_done_cyc);
      if (exp_done) begin
        exp_sum = m_res[W-1:0]; exp_cout = m_res[W]; exp_id = m_owner;
        n_done++;
      end
    end
    cyc++;
  endtask

  task automatic compare(input string name, input logic [W:0] act, input logic [W:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic checkOutput();
    compare("gnt0", {8'd0, gnt0}, {8'd0, exp_gnt0});
    compare("gnt1", {8'd0, gnt1}, {8'd0, exp_gnt1});
    compare("busy", {8'd0, busy}, {8'd0, exp_busy});
    compare("done", {8'd0, done}, {8'd0, exp_done});
    compare("sum", {1'b0, sum}, {1'b0, exp_sum});
    compare("cout", {8'd0, cout}, {8'd0, exp_cout});
    compare("done_id", {8'd0, done_id}, {8'd0, exp_id});
  endtask

  // Requesters drop req in the grant cycle; in random mode they also raise, withdraw and scramble
  task automatic applyStimulus();
    if (exp_gnt0 && !persist) req0 = 0;
    if (exp_gnt1 && !persist) req1 = 0;
    if (rnd) begin
      if (exp_gnt0 && $urandom_range(0, 1) == 0) begin a0 = W'($urandom); b0 = W'($urandom); end
      if (exp_gnt1 && $urandom_range(0, 1) == 0) begin a1 = W'($urandom); b1 = W'($urandom); end
      if (!req0 && !exp_gnt0 && $urandom_range(0, 3) == 0) begin
        req0 = 1; a0 = W'($urandom); b0 = W'($urandom);
      end else if (req0 && !exp_gnt0 && $urandom_range(0, 31) == 0) begin
        req0 = 0;
      end
      if (!req1 && !exp_gnt1 && $urandom_range(0, 3) == 0) begin
        req1 = 1; a1 = W'($urandom); b1 = W'($urandom);
      end else if (req1 && !exp_gnt1 && $urandom_range(0, 31) == 0) begin
        req1 = 0;
      end
    end
  endtask

  task automatic tick();
    modelStep();
    @(negedge clock);
    checkOutput();
    applyStimulus();
  endtask

  task automatic wait_gnt(input int bound);
    int i = 0;
    do begin tick(); i++; end while (!(exp_gnt0 || exp_gnt1) && i < bound);
    if (!(exp_gnt0 || exp_gnt1)) begin
      total++; bad++;
      $display("[TB] FAIL wait_gnt: no grant within %0d cycles", bound);
    end
  endtask

  task automatic wait_done(input int bound);
    int i = 0;
    do begin tick(); i++; end while (!exp_done && i < bound);
    if (!exp_done) begin
      total++; bad++;
      $display("[TB] FAIL wait_done: no result within %0d cycles", bound);
    end
  endtask

  initial begin
    int start_done, limit;
    reset = 1; req0 = 0; req1 = 0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    tick(); tick();
    compare("reset_busy", {8'd0, busy}, 9'd0);
    compare("reset_sum", {1'b0, sum}, 9'd0);
    reset = 0;

    // Single requester 0
    req0 = 1; a0 = 8'hAF; b0 = 8'h10;
    wait_gnt(20);
    compare("t1_gnt0", {8'd0, gnt0}, 9'd1);
    wait_done(20);
    compare("t1_sum", {1'b0, sum}, 9'h0BF);
    compare("t1_cout", {8'd0, cout}, 9'd0);
    compare("t1_id", {8'd0, done_id}, 9'd0);

    // Single requester 1 with carry out
    req1 = 1; a1 = 8'hFF; b1 = 8'h01;
    wait_gnt(20);
    compare("t2_gnt1", {8'd0, gnt1}, 9'd1);
    wait_done(20);
    compare("t2_sum", {1'b0, sum}, 9'h000);
    compare("t2_cout", {8'd0, cout}, 9'd1);
    compare("t2_id", {8'd0, done_id}, 9'd1);

    // Both requesters held high from reset
    reset = 1; persist = 1;
    req0 = 1; a0 = 8'h80; b0 = 8'h80;
    req1 = 1; a1 = 8'h0F; b1 = 8'hF0;
    tick(); tick();
    reset = 0;
    wait_gnt(20);
    compare("t3_first_gnt0", {8'd0, gnt0}, 9'd1);
    wait_done(20);
    compare("t3_sum0", {1'b0, sum}, 9'h000);
    compare("t3_cout0", {8'd0, cout}, 9'd1);
    compare("t3_id0", {8'd0, done_id}, 9'd0);
    wait_gnt(20);
    compare("t3_second_gnt1", {8'd0, gnt1}, 9'd1);
    wait_done(20);
    compare("t3_sum1", {1'b0, sum}, 9'h0FF);
    compare("t3_cout1", {8'd0, cout}, 9'd0);
    compare("t3_id1", {8'd0, done_id}, 9'd1);
    wait_gnt(20);
    compare("t3_third_gnt0", {8'd0, gnt0}, 9'd1);
    persist = 0; req0 = 0; req1 = 0;
    wait_done(20);
    tick();

    // Reset during the fourth shift cycle aborts the add
    req0 = 1; a0 = 8'h55; b0 = 8'h55;
    wait_gnt(20);
    tick(); tick(); tick();
    reset = 1;
    tick();
    reset = 0;
    compare("t4_busy_after_reset", {8'd0, busy}, 9'd0);
    compare("t4_sum_after_reset", {1'b0, sum}, 9'd0);
    repeat (12) tick();
    req0 = 1; a0 = 8'h55; b0 = 8'h55;
    wait_done(30);
    compare("t4_sum", {1'b0, sum}, 9'h0AA);
    compare("t4_cout", {8'd0, cout}, 9'd0);
    tick();

    // Operands change after acceptance; a short pulse while busy is ignored
    req0 = 1; a0 = 8'h3C; b0 = 8'h3C;
    wait_gnt(20);
    a0 = 8'h00; b0 = 8'h00;
    tick(); tick();
    req0 = 1;
    tick();
    req0 = 0;
    wait_done(20);
    compare("t5_sum", {1'b0, sum}, 9'h078);
    compare("t5_cout", {8'd0, cout}, 9'd0);
    repeat (5) tick();

    // Randomized traffic from both requesters
    rnd = 1;
    start_done = n_done;
    limit = cyc + 20000;
    while (n_done < start_done + 200 && cyc < limit) tick();
    if (n_done < start_done + 200) begin
      total++; bad++;
      $display("[TB] FAIL random_adds: only %0d of 200 completed", n_done - start_done);
    end
    rnd = 0; req0 = 0; req1 = 0;
    repeat (W + 4) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
